fc_w_stream: RTL and testbench
==============================

// Module: fc_w_stream
// PURPOSE
//  Parametrised FC-layer weight store and row streamer; successor to the fixed 960-bit dual-port weight ROM.
//  Holds DEPTH rows of W_PER_ROW weights, loadable at run time.
//  On start, reads row_cnt consecutive rows from base_addr, using both RAM ports (two rows/cycle).
//  Emits rows in address order on a valid/ready stream to the FC MAC array, with a credit-based FIFO absorbing RAM latency.
// PARAMETERS
//  W_BITS     8     bits per weight
//  W_PER_ROW  120   weights per row; DATA_W = W_BITS*W_PER_ROW (960)
//  DEPTH      1024  rows stored; must be a power of 2
//  ADDR_W     $clog2(DEPTH)  row address width
//  RD_LAT     2     RAM read latency in cycles (1..3)
//  FIFO_DEPTH 8     output FIFO rows; must be >= 2*RD_LAT+2
// PORTS
//  clk        in   1       sole clock
//  rst_n      in   1       asynchronous active-low reset
//  wr_en      in   1       load a row; accepted only when wr_ready=1
//  wr_ready   out  1       = ~busy
//  wr_addr    in   ADDR_W  load row address
//  wr_data    in   DATA_W  load row data
//  start      in   1       one-cycle pulse; ignored while busy
//  base_addr  in   ADDR_W  first row, sampled on start
//  row_cnt    in   ADDR_W+1  rows to stream (0..DEPTH), sampled on start
//  busy       out  1       high from cycle after accepted start until done
//  done       out  1       one-cycle pulse at end of job
//  out_valid  out  1       row available
//  out_ready  in   1       consumer accepts row
//  out_data   out  DATA_W  row data, weight k at bits [k*W_BITS +: W_BITS]
// BEHAVIOUR
//  Reset: busy=0, done=0, out_valid=0, out_data=0, wr_ready=1, FSM=IDLE, FIFO empty.
//   RAM contents are not cleared.
//  FSM states: IDLE -> RUN on start; RUN -> DRAIN when all reads are issued;
//   DRAIN -> DONE when the in-flight count is 0 and the FIFO is empty after the last handshake;
//   DONE -> IDLE after 1 cycle with done=1.
//  start with row_cnt=0: IDLE -> DONE directly; busy=1 for 1 cycle, done pulses, no output rows.
//  Issue (RUN): port A reads the lower address and port B the next one.
//   Issue 2 rows when remaining>=2 and free>=2; issue 1 row (port A) when remaining==1 or free==1.
//   free = FIFO_DEPTH - fifo_count - inflight.
//  Addresses increment modulo DEPTH: base_addr=DEPTH-1 wraps to row 0.
//  Read data enters the FIFO RD_LAT cycles after issue; port A data is pushed ahead of port B data in the same cycle.
//  Latency: start at cycle 0, first issue at cycle 1, first out_valid at cycle 2+RD_LAT (cycle 4 by default).
//  Sustained rate is 1 row/cycle while out_ready=1; out_ready=0 stalls issue via credits, with no overflow and no loss.
//  out_valid/out_data stay stable until the handshake.
//  wr_en while busy: ignored, RAM unchanged.
//  Write on cycle N followed by a start at N+1 reading the same row returns the new data.
//  start while busy: ignored, with no effect on the current job.
//  Async reset mid-job: job aborted, FIFO flushed, outputs take reset values; in-flight reads are discarded.
// STRUCTURE
//  Shared package fc_pkg: W_BITS, W_PER_ROW, DATA_W, FC_DEPTH constants, and the fc_w_state_e enum (IDLE/RUN/DRAIN/DONE).
//  Sub-module fc_w_ram: true dual-port RAM with RD_LAT output registers.
//   Port A is write/read; port B is read-only.
//   Inferable as block RAM; no reset on the data path.
//  Top level holds the FSM, address/remaining counters, in-flight credit counter, and the 2-push/1-pop FIFO.
// TESTING
//  Load rows 0..15 with data=row index replicated.
//   Start base=0, cnt=16, out_ready=1 -> 16 rows 0..15 in order, out_valid first at cycle 4, done 1 cycle after the last handshake.
//  Start base=1022, cnt=4 -> rows 1022, 1023, 0, 1 in order.
//  cnt=7, out_ready toggled 1010... plus a random 20-cycle hold-off -> exactly 7 rows, no duplicates.
//   fifo_count+inflight never exceeds FIFO_DEPTH.
//  start with cnt=0 -> done pulse at cycle 1, out_valid never asserted.
//   A second start while busy (cnt=5 job running) is ignored.
//  wr_en to row 3 during a busy job -> no change.
//   Write row 3=0xA5.. at idle, then start base=3, cnt=1 -> out_data=0xA5...
//  Assert rst_n=0 after the 3rd row of a 16-row job -> all outputs at reset values.
//   A new job base=0, cnt=2 then returns rows 0 and 1 with the old RAM contents intact.

Source files
------------

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared constants and state type for the FC weight streamer
package fc_pkg;

  localparam int W_BITS    = 8;
  localparam int W_PER_ROW = 120;
  localparam int DATA_W    = W_BITS * W_PER_ROW;
  localparam int FC_DEPTH  = 1024;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } fc_w_state_e;

endpackage

// File: rtl/fc_w_ram.sv
// rtl/fc_w_ram.sv - dual-port weight RAM, port A write/read, port B read, RD_LAT output stages
module fc_w_ram
  import fc_pkg::*;
#(
  parameter int DW     = DATA_W,
  parameter int DEPTH  = FC_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DW-1:0]     wdata_a,
  output logic [DW-1:0]     rdata_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DW-1:0]     rdata_b
);

  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] pipe_a [RD_LAT];
  logic [DW-1:0] pipe_b [RD_LAT];

  // Port A: write, plus read through the output register chain (old data on collision)
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    pipe_a[0] <= mem[addr_a];
    for (int i = 1; i < RD_LAT; i++) pipe_a[i] <= pipe_a[i-1];
  end

  // Port B: read-only through its own output register chain
  always_ff @(posedge clk) begin
    pipe_b[0] <= mem[addr_b];
    for (int i = 1; i < RD_LAT; i++) pipe_b[i] <= pipe_b[i-1];
  end

  assign rdata_a = pipe_a[RD_LAT-1];
  assign rdata_b = pipe_b[RD_LAT-1];

endmodule

// File: rtl/fc_w_stream.sv
// rtl/fc_w_stream.sv - FC weight store with two-rows-per-cycle credit-based row streamer
module fc_w_stream
  import fc_pkg::*;
#(
  parameter int W_BITS     = fc_pkg::W_BITS,
  parameter int W_PER_ROW  = fc_pkg::W_PER_ROW,
  parameter int DEPTH      = fc_pkg::FC_DEPTH,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [W_BITS*W_PER_ROW-1:0] wr_data,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [ADDR_W:0]             row_cnt,
  output logic                        busy,
  output logic                        done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [W_BITS*W_PER_ROW-1:0] out_data
);

  localparam int DW    = W_BITS * W_PER_ROW;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  fc_w_state_e       state, state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   remaining;
  logic [CNT_W-1:0]  inflight, fifo_count;
  logic [RD_LAT-1:0] vld_a, vld_b;
  logic [1:0]        n_issue, n_push;
  logic              push_a, push_b, pop;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DW-1:0]     fifo_mem [FIFO_DEPTH];
  logic [DW-1:0]     ram_rd_a, ram_rd_b;
  int                free_rows;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign busy      = (state != IDLE);
  assign wr_ready  = ~busy;
  assign done      = (state == DONE);
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
  assign pop       = out_valid & out_ready;
  assign push_a    = vld_a[RD_LAT-1];
  assign push_b    = vld_b[RD_LAT-1];
  assign n_push    = {1'b0, push_a} + {1'b0, push_b};

  // Port A carries loads while idle and the lower read address while busy
  fc_w_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT)
  ) u_ram (
    .clk    (clk),
    .we_a   (wr_en & ~busy),
    .addr_a (busy ? rd_addr : wr_addr),
    .wdata_a(wr_data),
    .rdata_a(ram_rd_a),
    .addr_b (rd_addr + 1'b1),
    .rdata_b(ram_rd_b)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and issue width; credits cover both buffered and in-flight rows
  always_comb begin
    state_nxt = state;
    n_issue   = 2'd0;
    free_rows = FIFO_DEPTH - int'(fifo_count) - int'(inflight);
    case (state)
      IDLE:  if (start) state_nxt = (row_cnt == '0) ? DONE : RUN;
      RUN: begin
        if (remaining >= (ADDR_W+1)'(2) && free_rows >= 2) n_issue = 2'd2;
        else if (remaining != '0 && free_rows >= 1)          n_issue = 2'd1;
        if (remaining == (ADDR_W+1)'(n_issue)) state_nxt = DRAIN;
      end
      DRAIN: if (inflight == '0 && (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop)))
               state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job counters, in-flight credits and read-valid shift registers matching RAM latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr   <= '0;
      remaining <= '0;
      inflight  <= '0;
      vld_a     <= '0;
      vld_b     <= '0;
    end else begin
      if (state == IDLE && start) begin
        rd_addr   <= base_addr;
        remaining <= row_cnt;
      end else begin
        rd_addr   <= rd_addr + ADDR_W'(n_issue);
        remaining <= remaining - (ADDR_W+1)'(n_issue);
      end
      inflight <= inflight + CNT_W'(n_issue) - CNT_W'(n_push);
      vld_a    <= (vld_a << 1) | RD_LAT'(n_issue != 2'd0);
      vld_b    <= (vld_b << 1) | RD_LAT'(n_issue == 2'd2);
    end
  end

  // FIFO pointers and occupancy; port A row lands ahead of port B row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_b)      wr_ptr <= ptr_inc(ptr_inc(wr_ptr));
      else if (push_a) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)         rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + CNT_W'(n_push) - CNT_W'(pop);
    end
  end

  // FIFO storage; data only, no reset
  always_ff @(posedge clk) begin
    if (push_a) fifo_mem[wr_ptr]          <= ram_rd_a;
    if (push_b) fifo_mem[ptr_inc(wr_ptr)] <= ram_rd_b;
  end

endmodule

// File: tb/tb_fc_w_stream.sv
// tb/tb_fc_w_stream.sv - self-checking bench for fc_w_stream
module tb_fc_w_stream;
  import fc_pkg::*;

  localparam int DW = 960;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   row_cnt = '0;
  logic          busy, done, out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;

  logic [DW-1:0] model [1024];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    int            mode;
    int            xs_cyc;
    int            wb_cyc;
  } job_t;

  job_t jobs [7];

  always #5 clk = ~clk;

  fc_w_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .base_addr(base_addr),
    .row_cnt  (row_cnt),
    .busy     (busy),
    .done     (done),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {120{b}};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual[63:0]=%h required[63:0]=%h", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic wr_row(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    model[a] = d;
  endtask

  task automatic run_job(input job_t j);
    logic [DW-1:0] got [$];
    int cyc, first_v, last_hs, done_cyc, hold, ovf, busy_c1, wr_rdy_b;
    hold = $urandom_range(2, 10);
    first_v = -1; last_hs = -1; done_cyc = -1; ovf = 0; cyc = 0; busy_c1 = 0; wr_rdy_b = 0;
    base_addr = j.base; row_cnt = j.cnt; start = 1'b1;
    while (done_cyc < 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0; wr_en = 1'b0;
      if (cyc == 1) busy_c1 = int'(busy);
      if (int'(dut.fifo_count) + int'(dut.inflight) > 8) ovf = 1;
      if (cyc == j.xs_cyc) begin start = 1'b1; base_addr = 10'd100; row_cnt = 11'd9; end
      if (cyc == j.wb_cyc) begin
        wr_en = 1'b1; wr_addr = 10'd3; wr_data = rep(8'hFF); wr_rdy_b = int'(wr_ready);
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (j.mode == 0)                      out_ready = 1'b1;
      else if (cyc >= hold && cyc < hold + 20) out_ready = 1'b0;
      else                                   out_ready = cyc[0];
      if (out_valid && out_ready) begin got.push_back(out_data); last_hs = cyc; end
      if (done) done_cyc = cyc;
    end
    chk("done_seen", int'(done_cyc >= 0), 1);
    chk("busy_cycle1", busy_c1, 1);
    chk("row_count", got.size(), int'(j.cnt));
    for (int i = 0; i < got.size() && i < int'(j.cnt); i++)
      chk_row("row_data", got[i], model[(int'(j.base) + i) % 1024]);
    if (j.cnt == '0) begin
      chk("zero_done_cycle", done_cyc, 1);
      chk("zero_no_valid", first_v, -1);
    end else begin
      chk("first_valid_cycle", first_v, 4);
      chk("done_after_last", done_cyc - last_hs, 1);
      if (j.mode == 0) chk("sustained_rate", last_hs - first_v, int'(j.cnt) - 1);
    end
    if (j.wb_cyc > 0) chk("wr_ready_busy", wr_rdy_b, 0);
    chk("credit_bound", ovf, 0);
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
    chk("idle_after_done", int'(busy), 0);
  endtask

  initial begin
    job_t rj;
    int hs, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk_row("rst_out_data", out_data, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) wr_row(AW'(i), rep(8'(i)));
    wr_row(10'd1022, rep(8'hFE));
    wr_row(10'd1023, rep(8'hFF));

    jobs[0] = '{10'd0,    11'd16, 0, -1, -1};
    jobs[1] = '{10'd1022, 11'd4,  0, -1, -1};
    jobs[2] = '{10'd5,    11'd7,  1, -1, -1};
    jobs[3] = '{10'd0,    11'd16, 1, -1, -1};
    jobs[4] = '{10'd10,   11'd0,  0, -1, -1};
    jobs[5] = '{10'd0,    11'd5,  0,  3,  2};
    jobs[6] = '{10'd3,    11'd1,  0, -1, -1};
    for (int k = 0; k < 7; k++) run_job(jobs[k]);

    wr_row(10'd3, rep(8'hA5));
    rj = '{10'd3, 11'd1, 0, -1, -1};
    run_job(rj);

    base_addr = 10'd0; row_cnt = 11'd16; start = 1'b1;
    hs = 0; n = 0;
    while (hs < 3 && n < 100) begin
      @(posedge clk); #1;
      start = 1'b0; out_ready = 1'b1; n++;
      if (out_valid) hs++;
    end
    chk("pre_reset_handshakes", hs, 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_wr_ready", int'(wr_ready), 1);
    chk_row("mid_rst_out_data", out_data, '0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rj = '{10'd0, 11'd2, 0, -1, -1};
    run_job(rj);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
